apple_spawner: RTL and testbench

Upstream stage of `draw_apple`. Chooses the grid cell for a new apple after a new-game request or after the snake eats the current apple. Candidates come from a free-running LFSR and are rejected if they fall outside the grid or, optionally, on a snake cell. The chosen position is committed only during vertical blanking, so `draw_apple` never changes position mid-frame.

---
 rtl/snake_pkg.sv | 33 +++
 rtl/apple_lfsr.sv | 26 ++
 rtl/apple_spawner.sv | 246 ++++++++++++++++++++++++
 tb/tb_apple_spawner.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake-game definitions: playfield defaults, apple LFSR constants,
// the apple spawner state encoding and the LFSR step helper.
package snake_pkg;

    localparam int          GRID_COLS_DEF = 64;
    localparam int          GRID_ROWS_DEF = 48;
    localparam int          MAX_TRIES_DEF = 255;
    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK   = 3'd1,
        QUERY  = 3'd2,
        WAIT   = 3'd3,
        SQUERY = 3'd4,
        SWAIT  = 3'd5,
        COMMIT = 3'd6
    } apple_state_t;

    // One right shift of the Galois LFSR; the mask is folded in when bit 0 falls out.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        logic [15:0] nxt;
        nxt = {1'b0, cur[15:1]};
        if (cur[0]) begin
            nxt = nxt ^ LFSR_MASK;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/apple_lfsr.sv
// Free-running 16-bit Galois LFSR feeding apple candidates. It never pauses,
// so the moment the player eats an apple decides which value gets used.
module apple_lfsr
    import snake_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [15:0] value
);

    logic [15:0] lfsr_r;

    // Advance every cycle; reload the (nonzero) seed on reset.
    always_ff @(posedge pclk) begin
        if (rst) begin
            lfsr_r <= SEED;
        end else begin
            lfsr_r <= lfsr_step(lfsr_r);
        end
    end

    assign value = lfsr_r;

endmodule

// File: rtl/apple_spawner.sv
// Picks the grid cell for a new apple after a new game or after the snake
// eats the current apple. Random candidates outside the grid are rejected;
// with APPLE_COLLISION_CHECK_EN defined, candidates on the snake are rejected
// too and a linear scan takes over after MAX_TRIES misses. The chosen cell is
// only published during vertical blanking so draw_apple never moves mid-frame.
module apple_spawner
    import snake_pkg::*;
#(
    parameter int          GRID_COLS = GRID_COLS_DEF,
    parameter int          GRID_ROWS = GRID_ROWS_DEF,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF,
    parameter int          MAX_TRIES = MAX_TRIES_DEF
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       start,
    input  logic       eaten,
    input  logic       vblnk_in,
    input  logic       occupied,
    output logic [6:0] query_x,
    output logic [5:0] query_y,
    output logic       query_valid,
    output logic [6:0] apple_x,
    output logic [5:0] apple_y,
    output logic       apple_valid,
    output logic       busy,
    output logic       full
);

    localparam logic [7:0] COLS_C      = 8'(GRID_COLS);
    localparam logic [6:0] ROWS_C      = 7'(GRID_ROWS);
    localparam logic [7:0] MAX_TRIES_C = 8'(MAX_TRIES);

    logic [15:0]  lfsr_s;
    logic         cand_ok_s;
    logic         unused_s;

    apple_state_t state_r, state_nx_s;
    logic [7:0]   tries_r, tries_nx_s;
    logic [6:0]   cand_x_r, cand_x_nx_s;
    logic [5:0]   cand_y_r, cand_y_nx_s;
    logic [6:0]   query_x_r, query_x_nx_s;
    logic [5:0]   query_y_r, query_y_nx_s;
    logic         query_valid_r, query_valid_nx_s;
    logic [6:0]   apple_x_r, apple_x_nx_s;
    logic [5:0]   apple_y_r, apple_y_nx_s;
    logic         apple_valid_r, apple_valid_nx_s;
    logic         busy_r, busy_nx_s;
    logic         full_r, full_nx_s;
`ifdef APPLE_COLLISION_CHECK_EN
    localparam logic [6:0] LAST_X_C = 7'(GRID_COLS - 1);
    localparam logic [5:0] LAST_Y_C = 6'(GRID_ROWS - 1);
    logic [6:0]   scan_x_r, scan_x_nx_s;
    logic [5:0]   scan_y_r, scan_y_nx_s;
`endif

    apple_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .pclk  (pclk),
        .rst   (rst),
        .value (lfsr_s)
    );

    // Unsigned range check widened by one bit so a full 128/64 grid works.
    assign cand_ok_s = ({1'b0, lfsr_s[6:0]} < COLS_C) && ({1'b0, lfsr_s[13:8]} < ROWS_C);

`ifdef APPLE_COLLISION_CHECK_EN
    assign unused_s = ^{lfsr_s[15:14], lfsr_s[7]};
`else
    assign unused_s = ^{lfsr_s[15:14], lfsr_s[7], occupied};
`endif

    // Next-state and next-register values; start restarts from any state.
    always_comb begin
        state_nx_s       = state_r;
        tries_nx_s       = tries_r;
        cand_x_nx_s      = cand_x_r;
        cand_y_nx_s      = cand_y_r;
        query_x_nx_s     = query_x_r;
        query_y_nx_s     = query_y_r;
        query_valid_nx_s = 1'b0;
        apple_x_nx_s     = apple_x_r;
        apple_y_nx_s     = apple_y_r;
        apple_valid_nx_s = apple_valid_r;
        full_nx_s        = full_r;
`ifdef APPLE_COLLISION_CHECK_EN
        scan_x_nx_s      = scan_x_r;
        scan_y_nx_s      = scan_y_r;
`endif
        if (start) begin
            state_nx_s       = PICK;
            tries_nx_s       = 8'd0;
            apple_valid_nx_s = 1'b0;
            full_nx_s        = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (eaten) begin
                        state_nx_s       = PICK;
                        tries_nx_s       = 8'd0;
                        apple_valid_nx_s = 1'b0;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                PICK: begin
                    if (tries_r == MAX_TRIES_C) begin
`ifdef APPLE_COLLISION_CHECK_EN
                        scan_x_nx_s      = 7'd0;
                        scan_y_nx_s      = 6'd0;
                        query_x_nx_s     = 7'd0;
                        query_y_nx_s     = 6'd0;
                        query_valid_nx_s = 1'b1;
                        state_nx_s       = SQUERY;
`else
                        cand_x_nx_s = 7'd0;
                        cand_y_nx_s = 6'd0;
                        state_nx_s  = COMMIT;
`endif
                    end else if (cand_ok_s) begin
                        cand_x_nx_s = lfsr_s[6:0];
                        cand_y_nx_s = lfsr_s[13:8];
`ifdef APPLE_COLLISION_CHECK_EN
                        query_x_nx_s     = lfsr_s[6:0];
                        query_y_nx_s     = lfsr_s[13:8];
                        query_valid_nx_s = 1'b1;
                        state_nx_s       = QUERY;
`else
                        state_nx_s  = COMMIT;
`endif
                    end else begin
                        tries_nx_s = tries_r + 8'd1;
                    end
                end
`ifdef APPLE_COLLISION_CHECK_EN
                QUERY: begin
                    state_nx_s = WAIT;
                end
                WAIT: begin
                    if (occupied) begin
                        tries_nx_s = tries_r + 8'd1;
                        state_nx_s = PICK;
                    end else begin
                        state_nx_s = COMMIT;
                    end
                end
                SQUERY: begin
                    state_nx_s = SWAIT;
                end
                SWAIT: begin
                    if (!occupied) begin
                        cand_x_nx_s = scan_x_r;
                        cand_y_nx_s = scan_y_r;
                        state_nx_s  = COMMIT;
                    end else if ((scan_x_r == LAST_X_C) && (scan_y_r == LAST_Y_C)) begin
                        full_nx_s        = 1'b1;
                        apple_valid_nx_s = 1'b0;
                        state_nx_s       = IDLE;
                    end else begin
                        if (scan_x_r == LAST_X_C) begin
                            scan_x_nx_s = 7'd0;
                            scan_y_nx_s = scan_y_r + 6'd1;
                        end else begin
                            scan_x_nx_s = scan_x_r + 7'd1;
                            scan_y_nx_s = scan_y_r;
                        end
                        query_x_nx_s     = scan_x_nx_s;
                        query_y_nx_s     = scan_y_nx_s;
                        query_valid_nx_s = 1'b1;
                        state_nx_s       = SQUERY;
                    end
                end
`endif
                COMMIT: begin
                    if (vblnk_in) begin
                        apple_x_nx_s     = cand_x_r;
                        apple_y_nx_s     = cand_y_r;
                        apple_valid_nx_s = 1'b1;
                        state_nx_s       = IDLE;
                    end else begin
                        state_nx_s = COMMIT;
                    end
                end
                default: begin
                    state_nx_s = IDLE;
                end
            endcase
        end
        busy_nx_s = (state_nx_s != IDLE);
    end

    // State register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Counter, candidate and output registers.
    always_ff @(posedge pclk) begin
        if (rst) begin
            tries_r       <= 8'd0;
            cand_x_r      <= 7'd0;
            cand_y_r      <= 6'd0;
            query_x_r     <= 7'd0;
            query_y_r     <= 6'd0;
            query_valid_r <= 1'b0;
            apple_x_r     <= 7'd0;
            apple_y_r     <= 6'd0;
            apple_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            full_r        <= 1'b0;
`ifdef APPLE_COLLISION_CHECK_EN
            scan_x_r      <= 7'd0;
            scan_y_r      <= 6'd0;
`endif
        end else begin
            tries_r       <= tries_nx_s;
            cand_x_r      <= cand_x_nx_s;
            cand_y_r      <= cand_y_nx_s;
            query_x_r     <= query_x_nx_s;
            query_y_r     <= query_y_nx_s;
            query_valid_r <= query_valid_nx_s;
            apple_x_r     <= apple_x_nx_s;
            apple_y_r     <= apple_y_nx_s;
            apple_valid_r <= apple_valid_nx_s;
            busy_r        <= busy_nx_s;
            full_r        <= full_nx_s;
`ifdef APPLE_COLLISION_CHECK_EN
            scan_x_r      <= scan_x_nx_s;
            scan_y_r      <= scan_y_nx_s;
`endif
        end
    end

    assign query_x     = query_x_r;
    assign query_y     = query_y_r;
    assign query_valid = query_valid_r;
    assign apple_x     = apple_x_r;
    assign apple_y     = apple_y_r;
    assign apple_valid = apple_valid_r;
    assign busy        = busy_r;
    assign full        = full_r;

endmodule

// File: tb/tb_apple_spawner.sv
// Self-checking bench for apple_spawner. Expected placements come from an
// independent LFSR/placement model and are queued when a request is driven,
// then popped when the spawner goes idle again.
module tb_apple_spawner;

    localparam int          COLS = 64;
    localparam int          ROWS = 48;
    localparam int          MAXT = 255;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       pclk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       eaten = 1'b0;
    logic       vblnk_in = 1'b0;
    logic       occupied = 1'b0;
    logic [6:0] query_x;
    logic [5:0] query_y;
    logic       query_valid;
    logic [6:0] apple_x;
    logic [5:0] apple_y;
    logic       apple_valid;
    logic       busy;
    logic       full;

    apple_spawner #(
        .GRID_COLS (COLS),
        .GRID_ROWS (ROWS),
        .LFSR_SEED (SEED),
        .MAX_TRIES (MAXT)
    ) dut (
        .pclk        (pclk),
        .rst         (rst),
        .start       (start),
        .eaten       (eaten),
        .vblnk_in    (vblnk_in),
        .occupied    (occupied),
        .query_x     (query_x),
        .query_y     (query_y),
        .query_valid (query_valid),
        .apple_x     (apple_x),
        .apple_y     (apple_y),
        .apple_valid (apple_valid),
        .busy        (busy),
        .full        (full)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [6:0]  x;
        logic [5:0]  y;
        logic        full;
        logic [31:0] lat;
        logic [31:0] nq;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          tot_q = 0;
    int          q_base = 0;
    int          exp_tot = 0;
    int          occ_limit = 0;
    logic        occ_next = 1'b0;
    logic [15:0] m_lfsr = SEED;
    logic [6:0]  last_x = 7'd0;
    logic [5:0]  last_y = 6'd0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        if (v[0] == 1'b1) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic logic in_grid(input logic [15:0] v);
        return (int'(v[6:0]) < COLS) && (int'(v[13:8]) < ROWS);
    endfunction

    // Placement model: v0 is the LFSR value seen by the first PICK edge (N+1);
    // k is how many queries the responder will answer as occupied.
    function automatic exp_t predict(input logic [15:0] v0, input int k);
        exp_t r;
        logic [15:0] v;
        int tries, t, used, idx;
        logic done;
        v = v0; tries = 0; t = 1; used = 0; done = 1'b0;
        r = '0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (tries == MAXT) begin
`ifdef APPLE_COLLISION_CHECK_EN
                idx = k - used;
                if (idx < COLS * ROWS) begin
                    r.x = 7'(idx % COLS); r.y = 6'(idx / COLS);
                    r.lat = t + 3 + 2 * idx; r.nq = used + idx + 1;
                end else begin
                    r.full = 1'b1; r.lat = t + 2 * COLS * ROWS; r.nq = used + COLS * ROWS;
                end
`else
                r.x = 7'd0; r.y = 6'd0; r.lat = t + 1; r.nq = 0;
`endif
                done = 1'b1;
            end else if (in_grid(v)) begin
`ifdef APPLE_COLLISION_CHECK_EN
                if (used < k) begin
                    used++; tries++; t += 3;
                    v = lfsr_next(lfsr_next(lfsr_next(v)));
                end else begin
                    r.x = v[6:0]; r.y = v[13:8]; r.lat = t + 3; r.nq = used + 1;
                    done = 1'b1;
                end
`else
                r.x = v[6:0]; r.y = v[13:8]; r.lat = t + 1; r.nq = 0;
                done = 1'b1;
`endif
            end else begin
                tries++; t += 1; v = lfsr_next(v);
            end
        end
        return r;
    endfunction

    // Reference LFSR, stepped alongside the DUT from the same reset.
    always @(posedge pclk) begin
        m_lfsr <= rst ? SEED : lfsr_next(m_lfsr);
    end

    // Snake-memory responder: answers each query one cycle after query_valid.
    always @(negedge pclk) begin
        occupied <= occ_next;
        if (query_valid === 1'b1) begin
            occ_next <= ((tot_q - q_base) < occ_limit);
            tot_q    <= tot_q + 1;
        end else begin
            occ_next <= 1'b0;
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk_val({tag, "_ax"}, apple_x, 0);
        chk_val({tag, "_ay"}, apple_y, 0);
        chk_val({tag, "_qx"}, query_x, 0);
        chk_val({tag, "_qy"}, query_y, 0);
        chk_val({tag, "_qv"}, query_valid, 0);
        chk_val({tag, "_av"}, apple_valid, 0);
        chk_val({tag, "_busy"}, busy, 0);
        chk_val({tag, "_full"}, full, 0);
    endtask

    // Compare the DUT state after a placement against the oldest queued expectation.
    task automatic check_result(input int cnt);
        exp_t e;
        e = sb_q.pop_front();
        chk_val("latency", cnt, e.lat);
        chk_val("busy_off", busy, 0);
        chk_val("full", full, {31'd0, e.full});
        chk_val("apple_valid", apple_valid, {31'd0, ~e.full});
        chk_val("queries", tot_q - q_base, e.nq);
        if (!e.full) begin
            chk_val("apple_x", apple_x, e.x);
            chk_val("apple_y", apple_y, e.y);
            chk_val("x_in_grid", (int'(apple_x) < COLS), 1);
            chk_val("y_in_grid", (int'(apple_y) < ROWS), 1);
            last_x = e.x;
            last_y = e.y;
        end
        exp_tot += e.nq;
    endtask

    // Drive one request and wait (bounded) for the spawner to go idle.
    task automatic do_req(input logic st, input logic ea, input int extra_eat);
        int cnt;
        @(negedge pclk);
        sb_q.push_back(predict(lfsr_next(m_lfsr), occ_limit));
        q_base = tot_q;
        start = st;
        eaten = ea;
        @(posedge pclk); #1;
        start = 1'b0;
        eaten = 1'b0;
        if (st) chk_val("full_cleared", full, 0);
        chk_val("busy_on", busy, 1);
        cnt = 0;
        while (busy === 1'b1 && cnt < 20000) begin
            @(posedge pclk); #1;
            cnt++;
            eaten = (cnt == extra_eat);
        end
        eaten = 1'b0;
        if (cnt >= 20000) chk_val("timeout", 1, 0);
        check_result(cnt);
    endtask

    initial begin
        exp_t e;
        int bad;
        int g;

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        rst = 1'b0;
        chk_reset_outputs("reset");

        // First placement from the seed, blanking active, nothing occupied.
        vblnk_in = 1'b1;
        occ_limit = 0;
        do_req(1'b1, 1'b0, 0);

        // Eaten with blanking held low: stuck in COMMIT until vblnk rises.
        @(negedge pclk);
        vblnk_in = 1'b0;
        occ_limit = 0;
        e = predict(lfsr_next(m_lfsr), 0);
        q_base = tot_q;
        eaten = 1'b1;
        @(posedge pclk); #1;
        eaten = 1'b0;
        chk_val("eat_av_clr", apple_valid, 0);
        chk_val("eat_busy", busy, 1);
        repeat (1000) @(posedge pclk);
        #1;
        chk_val("hold_av", apple_valid, 0);
        chk_val("hold_busy", busy, 1);
        chk_val("hold_ax", apple_x, last_x);
        chk_val("hold_ay", apple_y, last_y);
        @(negedge pclk);
        vblnk_in = 1'b1;
        @(posedge pclk); #1;
        chk_val("vbl_av", apple_valid, 1);
        chk_val("vbl_busy", busy, 0);
        chk_val("vbl_ax", apple_x, e.x);
        chk_val("vbl_ay", apple_y, e.y);
        chk_val("vbl_queries", tot_q - q_base, e.nq);
        exp_tot += e.nq;
        last_x = e.x;
        last_y = e.y;

        // First three queries answered occupied.
        occ_limit = 3;
        do_req(1'b0, 1'b1, 0);

        // Everything occupied: random phase, full scan, then full.
        occ_limit = 1000000;
        do_req(1'b0, 1'b1, 0);
        occ_limit = 0;
        do_req(1'b1, 1'b0, 0);

        // start and eaten together, then a stray eaten while busy.
        do_req(1'b1, 1'b1, 1);
        bad = 0;
        repeat (20) begin
            @(posedge pclk); #1;
            if (busy !== 1'b0 || apple_valid !== 1'b1) bad++;
        end
        chk_val("one_commit", bad, 0);

        // Reset in the middle of a placement.
        @(negedge pclk);
        vblnk_in = 1'b0;
        start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
`ifdef APPLE_COLLISION_CHECK_EN
        g = 0;
        while (query_valid !== 1'b1 && g < 5000) begin
            @(negedge pclk);
            g++;
        end
        chk_val("qv_before_rst", query_valid, 1);
        @(negedge pclk);
        exp_tot += 1;
`else
        g = 0;
        repeat (6) @(negedge pclk);
`endif
        chk_val("busy_before_rst", busy, 1);
        rst = 1'b1;
        @(posedge pclk); #1;
        chk_reset_outputs("midrst");
        @(negedge pclk);
        rst = 1'b0;
        vblnk_in = 1'b1;
        do_req(1'b1, 1'b0, 0);

        chk_val("qv_total", tot_q, exp_tot);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
